// File: rtl/pipeline_scoreboard_pkg.sv
// Shared types for the decode-side hazard controller: opcode constants,
// FSM encoding, scoreboard slot layout and source-usage decode helpers.
package pipeline_scoreboard_pkg;

    localparam logic [6:0] RTYPE  = 7'b0110011;
    localparam logic [6:0] STYPE  = 7'b0100011;
    localparam logic [6:0] SBTYPE = 7'b1100011;
    localparam logic [6:0] ITYPE  = 7'b0000011;

    typedef enum logic {
        RUN     = 1'b0,
        FLUSHED = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
    } slot_t;

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == RTYPE) || (op == STYPE) ||
               (op == SBTYPE) || (op == ITYPE);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == RTYPE) || (op == STYPE) || (op == SBTYPE);
    endfunction

endpackage

// File: rtl/pipeline_scoreboard_slots.sv
// scoreboard_slots: shift register of in-flight writes (EX..WB), source compare, pending mask.
// Ports: clock/reset, slot_in (new slot0 entry), rs1/rs2 + use flags, match, pending_mask.
module scoreboard_slots
    import pipeline_scoreboard_pkg::*;
#(
    parameter int unsigned WB_LATENCY    = 3,
    parameter bit          WRITE_THROUGH = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  slot_t       slot_in,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic        use_rs1,
    input  logic        use_rs2,
    output logic        match,
    output logic [31:0] pending_mask
);

    // With a write-through register file the oldest slot's value is
    // already visible to the reader, so it is left out of the compare.
    localparam int unsigned CMP_N = WRITE_THROUGH ? WB_LATENCY - 1 : WB_LATENCY;

    slot_t slots [WB_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WB_LATENCY; i++) slots[i] <= '0;
        end else begin
            slots[0] <= slot_in;
            for (int i = 1; i < WB_LATENCY; i++) slots[i] <= slots[i-1];
        end
    end

    always_comb begin
        match        = 1'b0;
        pending_mask = '0;
        for (int i = 0; i < WB_LATENCY; i++) begin
            if (slots[i].valid) begin
                pending_mask[slots[i].rd] = 1'b1;
                if (i < CMP_N) begin
                    if (use_rs1 && rs1 != 5'd0 && rs1 == slots[i].rd) match = 1'b1;
                    if (use_rs2 && rs2 != 5'd0 && rs2 == slots[i].rd) match = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard: RAW stall / bubble / branch-flush controller beside ID.
// Ports: ID instruction fields in; PC/IF-ID enables, bubble, flush, pending mask, stall stats out.
module pipeline_scoreboard
    import pipeline_scoreboard_pkg::*;
#(
    parameter int unsigned WB_LATENCY    = 3,
    parameter bit          WRITE_THROUGH = 1'b0,
    parameter int unsigned CNT_W         = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [6:0]       inst_opcode,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [4:0]       rd,
    input  logic             reg_write,
    input  logic             branch_taken,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             stall_pipeline,
    output logic             if_flush,
    output logic [31:0]      pending_mask,
    output logic [CNT_W-1:0] stall_count,
    output logic             stall_error
);

    // Run length saturates one past WB_LATENCY, enough to flag an overlong stall.
    localparam int unsigned    RUN_W   = $clog2(WB_LATENCY + 2);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WB_LATENCY + 1);
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(WB_LATENCY);

    state_t           state;
    slot_t            slot_in;
    logic             match;
    logic             hazard;
    logic [RUN_W-1:0] run_len;

    scoreboard_slots #(
        .WB_LATENCY   (WB_LATENCY),
        .WRITE_THROUGH(WRITE_THROUGH)
    ) u_slots (
        .clock       (clock),
        .reset       (reset),
        .slot_in     (slot_in),
        .rs1         (rs1),
        .rs2         (rs2),
        .use_rs1     (uses_rs1(inst_opcode)),
        .use_rs2     (uses_rs2(inst_opcode)),
        .match       (match),
        .pending_mask(pending_mask)
    );

    assign hazard         = issue_valid && (state == RUN) && match;
    assign pc_enable      = !hazard;
    assign if_id_enable   = !hazard;
    assign stall_pipeline = hazard || (state == FLUSHED);
    assign if_flush       = (state == RUN) && branch_taken && !hazard;

    // Only an accepted instruction in RUN enters the scoreboard;
    // stalls and the post-flush slot push a bubble.
    always_comb begin
        slot_in = '0;
        if (state == RUN && !hazard) begin
            slot_in.valid = issue_valid && reg_write && (rd != 5'd0);
            slot_in.rd    = rd;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            stall_count <= '0;
            run_len     <= '0;
            stall_error <= 1'b0;
        end else begin
            state <= if_flush ? FLUSHED : RUN;
            if (hazard) begin
                if (stall_count != '1) stall_count <= stall_count + 1'b1;
                if (run_len != RUN_MAX) run_len <= run_len + 1'b1;
                if (run_len >= RUN_LIM) stall_error <= 1'b1;
            end else begin
                run_len <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Testbench for pipeline_scoreboard: two instances (WT=0/CNT_W=16, WT=1/CNT_W=2)
// share stimulus; directed scenarios plus random traffic against a timing model.
module tb_pipeline_scoreboard;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_SB = 7'b1100011;
    localparam logic [6:0] OP_L  = 7'b0000011;
    localparam logic [6:0] OP_I  = 7'b0010011;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [6:0]  inst_opcode = '0;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        reg_write = 1'b0;
    logic        branch_taken = 1'b0;

    logic [1:0]  pc_en, ifid_en, stall, flush, err;
    logic [31:0] mask [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    pipeline_scoreboard #(.WB_LATENCY(3), .WRITE_THROUGH(1'b0), .CNT_W(16)) dut0 (
        .clock(clock), .reset(reset), .issue_valid(issue_valid),
        .inst_opcode(inst_opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_write(reg_write), .branch_taken(branch_taken),
        .pc_enable(pc_en[0]), .if_id_enable(ifid_en[0]),
        .stall_pipeline(stall[0]), .if_flush(flush[0]),
        .pending_mask(mask[0]), .stall_count(cnt0), .stall_error(err[0])
    );

    pipeline_scoreboard #(.WB_LATENCY(3), .WRITE_THROUGH(1'b1), .CNT_W(2)) dut1 (
        .clock(clock), .reset(reset), .issue_valid(issue_valid),
        .inst_opcode(inst_opcode), .rs1(rs1), .rs2(rs2), .rd(rd),
        .reg_write(reg_write), .branch_taken(branch_taken),
        .pc_enable(pc_en[1]), .if_id_enable(ifid_en[1]),
        .stall_pipeline(stall[1]), .if_flush(flush[1]),
        .pending_mask(mask[1]), .stall_count(cnt1), .stall_error(err[1])
    );

    // Model: each register records the last cycle in which a reader must
    // still stall on it and the last cycle in which it shows as pending.
    int          cyc = 0;
    int          busy [2][32];
    int          pend [2][32];
    bit          fl [2];
    int          cnt [2];
    int          run [2];
    bit          er [2];
    bit          e_haz [2];
    logic [31:0] e_mask [2];

    function automatic int cmp_win(input int k);
        return (k == 0) ? 3 : 2;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 0) ? 65535 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) begin
                busy[k][r] = -1;
                pend[k][r] = -1;
            end
            fl[k] = 0; cnt[k] = 0; run[k] = 0; er[k] = 0;
        end
    endtask

    task automatic model_eval();
        bit u1, u2;
        u1 = inst_opcode inside {OP_R, OP_S, OP_SB, OP_L};
        u2 = inst_opcode inside {OP_R, OP_S, OP_SB};
        for (int k = 0; k < 2; k++) begin
            e_haz[k] = issue_valid && !fl[k] &&
                ((u1 && rs1 != 0 && cyc <= busy[k][rs1]) ||
                 (u2 && rs2 != 0 && cyc <= busy[k][rs2]));
            for (int r = 0; r < 32; r++) e_mask[k][r] = (cyc <= pend[k][r]);
        end
    endtask

    task automatic model_advance();
        bit nf;
        for (int k = 0; k < 2; k++) begin
            if (!fl[k] && !e_haz[k] && issue_valid && reg_write && rd != 0) begin
                busy[k][rd] = cyc + cmp_win(k);
                pend[k][rd] = cyc + 3;
            end
            if (e_haz[k]) begin
                if (cnt[k] < cnt_max(k)) cnt[k]++;
                run[k]++;
                if (run[k] > 3) er[k] = 1;
            end else begin
                run[k] = 0;
            end
            nf = !fl[k] && branch_taken && !e_haz[k];
            fl[k] = nf;
        end
        cyc++;
    endtask

    task automatic drive(input bit iv, input logic [6:0] op, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d,
                         input bit rw, input bit bt);
        issue_valid = iv; inst_opcode = op; rs1 = a; rs2 = b; rd = d;
        reg_write = rw; branch_taken = bt;
        #2;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clock);
        model_advance();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clock);
        model_reset();
        cyc++;
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        drive(1, OP_R, 1, 2, 5, 1, 0); tick();
        drive(1, OP_R, 1, 2, 6, 1, 0); tick();
        drive(1, OP_R, 5, 6, 7, 1, 0);
        checks++;
        if (mask[0] !== 32'h60) begin
            failures++;
            $display("FAIL reset_preload_mask got=%h exp=%h", mask[0], 32'h60);
        end
        tick();
        apply_reset();
        drive(0, OP_I, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (mask[k] !== 32'h0 || pc_en[k] !== 1'b1 || stall[k] !== 1'b0 ||
                flush[k] !== 1'b0 || err[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d mask=%h pc=%b stall=%b flush=%b err=%b",
                         k, mask[k], pc_en[k], stall[k], flush[k], err[k]);
            end
        end
        checks++;
        if (cnt0 !== 16'd0 || cnt1 !== 2'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d/%0d exp=0/0", cnt0, cnt1);
        end
        tick();
    endtask

    task automatic test_raw_back_to_back();
        int ns [2];
        int npc;
        int acc;
        ns = '{0, 0}; npc = 0; acc = -1;
        apply_reset();
        drive(1, OP_R, 1, 2, 5, 1, 0);
        checks++;
        if (stall[0] !== 1'b0) begin
            failures++;
            $display("FAIL raw_first_issue got=%b exp=0", stall[0]);
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1, OP_R, 5, 1, 6, 1, 0);
            for (int k = 0; k < 2; k++) if (stall[k]) ns[k]++;
            if (!pc_en[0]) npc++;
            if (pc_en[0] && acc < 0) acc = i;
            tick();
        end
        checks++;
        if (ns[0] != 3 || npc != 3 || acc != 3) begin
            failures++;
            $display("FAIL raw_wt0 stalls=%0d pc_off=%0d accept=%0d exp=3/3/3", ns[0], npc, acc);
        end
        checks++;
        if (ns[1] != 2) begin
            failures++;
            $display("FAIL raw_wt1 stalls got=%0d exp=2", ns[1]);
        end
        checks++;
        if (cnt0 !== 16'd3 || cnt1 !== 2'd2) begin
            failures++;
            $display("FAIL raw_count got=%0d/%0d exp=3/2", cnt0, cnt1);
        end
    endtask

    task automatic test_x0();
        apply_reset();
        drive(1, OP_R, 1, 2, 0, 1, 0); tick();
        drive(1, OP_R, 0, 0, 3, 0, 0);
        checks++;
        if (stall !== 2'b00 || mask[0] !== 32'h0) begin
            failures++;
            $display("FAIL x0_no_hazard stall=%b mask=%h exp=00/0", stall, mask[0]);
        end
        tick();
    endtask

    task automatic test_branch_flush();
        apply_reset();
        drive(1, OP_SB, 1, 2, 0, 0, 1);
        checks++;
        if (flush !== 2'b11 || stall !== 2'b00 || pc_en !== 2'b11) begin
            failures++;
            $display("FAIL br_flush flush=%b stall=%b pc=%b exp=11/00/11", flush, stall, pc_en);
        end
        tick();
        drive(1, OP_R, 1, 2, 3, 1, 0);
        checks++;
        if (flush[0] !== 1'b0 || stall[0] !== 1'b1 || pc_en[0] !== 1'b1) begin
            failures++;
            $display("FAIL br_bubble flush=%b stall=%b pc=%b exp=0/1/1", flush[0], stall[0], pc_en[0]);
        end
        tick();
        drive(0, OP_I, 0, 0, 0, 0, 0);
        checks++;
        if (mask[0] !== 32'h0 || stall[0] !== 1'b0 || cnt0 !== 16'd0) begin
            failures++;
            $display("FAIL br_after mask=%h stall=%b cnt=%0d exp=0/0/0", mask[0], stall[0], cnt0);
        end
        tick();
        drive(1, OP_R, 1, 2, 3, 1, 0); tick();
        drive(0, OP_I, 0, 0, 0, 0, 0);
        checks++;
        if (mask[0] !== 32'h8) begin
            failures++;
            $display("FAIL br_run_issue mask got=%h exp=%h", mask[0], 32'h8);
        end
        tick();
    endtask

    task automatic test_branch_stalled();
        apply_reset();
        drive(1, OP_R, 0, 0, 1, 1, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, OP_SB, 1, 2, 0, 0, 1);
            checks++;
            if (flush[0] !== (i == 3) || stall[0] !== (i < 3)) begin
                failures++;
                $display("FAIL br_stalled i=%0d flush=%b stall=%b exp=%b/%b",
                         i, flush[0], stall[0], (i == 3), (i < 3));
            end
            tick();
        end
        drive(0, OP_I, 0, 0, 0, 0, 0);
        checks++;
        if (stall[0] !== 1'b1 || flush[0] !== 1'b0) begin
            failures++;
            $display("FAIL br_stalled_bubble stall=%b flush=%b exp=1/0", stall[0], flush[0]);
        end
        tick();
    endtask

    task automatic test_load_mem();
        int ns [2];
        ns = '{0, 0};
        apply_reset();
        drive(1, OP_R, 0, 0, 3, 1, 0); tick();
        drive(1, OP_I, 3, 3, 9, 0, 0);
        checks++;
        if (stall[0] !== 1'b0) begin
            failures++;
            $display("FAIL ld_other_op stall got=%b exp=0", stall[0]);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, OP_L, 3, 0, 7, 1, 0);
            for (int k = 0; k < 2; k++) if (stall[k]) ns[k]++;
            tick();
        end
        checks++;
        if (ns[0] != 2 || ns[1] != 1) begin
            failures++;
            $display("FAIL ld_mem stalls got=%0d/%0d exp=2/1", ns[0], ns[1]);
        end
        drive(1, OP_L, 0, 7, 8, 1, 0);
        checks++;
        if (stall !== 2'b00) begin
            failures++;
            $display("FAIL ld_rs2_unused stall got=%b exp=00", stall);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        ops = '{OP_R, OP_S, OP_SB, OP_L, OP_I, 7'h00};
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                apply_reset();
                continue;
            end
            ops[5] = 7'($urandom);
            drive($urandom_range(0, 9) < 8, ops[$urandom_range(0, 5)],
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 9) == 0);
            for (int k = 0; k < 2; k++) begin
                automatic int  gc = (k == 0) ? int'(cnt0) : int'(cnt1);
                automatic bit  ep = !e_haz[k];
                automatic bit  es = e_haz[k] || fl[k];
                automatic bit  ef = !fl[k] && branch_taken && !e_haz[k];
                checks++;
                if (pc_en[k] !== ep || ifid_en[k] !== ep || stall[k] !== es ||
                    flush[k] !== ef) begin
                    failures++;
                    $display("FAIL rnd_ctrl dut%0d cyc=%0d pc=%b ifid=%b stall=%b flush=%b exp=%b/%b/%b/%b",
                             k, cyc, pc_en[k], ifid_en[k], stall[k], flush[k], ep, ep, es, ef);
                end
                checks++;
                if (mask[k] !== e_mask[k] || gc != cnt[k] || err[k] !== er[k]) begin
                    failures++;
                    $display("FAIL rnd_state dut%0d cyc=%0d mask=%h cnt=%0d err=%b exp=%h/%0d/%b",
                             k, cyc, mask[k], gc, err[k], e_mask[k], cnt[k], er[k]);
                end
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_raw_back_to_back();
        test_x0();
        test_branch_flush();
        test_branch_stalled();
        test_load_mem();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_scoreboard.md
Name: pipeline_scoreboard

Overview:
- Hazard controller for the 5-stage RV32 pipeline; sits beside the decode stage.
- Tracks in-flight destination registers in a shift-register scoreboard covering EX, MEM and WB.
- Stalls fetch/decode and injects ID/EX bubbles on RAW hazards.
- Sequences the one-cycle IF flush on taken branches; keeps a saturating stall counter for performance reporting.

Parameters:
- WB_LATENCY, 3: number of scoreboard slots, one per stage between ID and register-file write (EX, MEM, WB).
- WRITE_THROUGH, 0: 1 = register file forwards same-cycle writes, so the last slot is excluded from hazard compare; 0 = all slots compared.
- CNT_W, 16: width of the stall counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- issue_valid  in  1  ID holds a valid instruction.
- inst_opcode  in  7  opcode of the ID instruction.
- rs1  in  5  source register 1 of the ID instruction.
- rs2  in  5  source register 2 of the ID instruction.
- rd  in  5  destination register of the ID instruction.
- reg_write  in  1  control unit reg_write for the ID instruction.
- branch_taken  in  1  beq resolved taken in ID this cycle.
- pc_enable  out  1  PC update enable.
- if_id_enable  out  1  IF/ID register load enable.
- stall_pipeline  out  1  zero ID/EX control fields (bubble).
- if_flush  out  1  squash the IF/ID contents.
- pending_mask  out  32  bit n set = x n has a write in flight.
- stall_count  out  CNT_W  saturating count of stall cycles.
- stall_error  out  1  sticky: stall lasted more than WB_LATENCY cycles.

Behaviour:
- Reset (synchronous, active-high): all slots invalid, FSM = RUN, stall_count = 0, stall_error = 0.
  - Outputs after reset: pc_enable = 1, if_id_enable = 1, stall_pipeline = 0, if_flush = 0, pending_mask = 0.
  - A reset asserted mid-stall or mid-flush drops all pending entries the same edge.
- Slot i holds {valid, rd}. Every rising edge: slot[i+1] <= slot[i]; slot[WB_LATENCY-1] retires. Slot0 loads as below.
- Source usage is decoded from inst_opcode:
  - R-type 0110011: uses rs1 and rs2.
  - S-type 0100011: uses rs1 and rs2.
  - SB-type 1100011: uses rs1 and rs2.
  - Load 0000011: uses rs1 only.
  - Any other opcode: uses no sources.
- hazard = issue_valid & FSM==RUN & (used rs matches a valid compared slot's rd). x0 never matches.
- Hazard cycle:
  - pc_enable = 0, if_id_enable = 0, stall_pipeline = 1.
  - Slot0 <= invalid (bubble).
  - stall_count += 1, saturating at all-ones.
- Accept, i.e. no hazard and FSM==RUN:
  - Slot0 <= {issue_valid & reg_write & rd!=0, rd}.
  - pc_enable = 1, if_id_enable = 1.
- Branch handling:
  - branch_taken & !hazard & FSM==RUN: if_flush = 1 combinationally, same cycle; next state FLUSHED.
  - branch_taken is ignored while hazard is high; the branch re-resolves once operands are clean.
- FLUSHED, exactly one cycle: the ID instruction is a bubble.
  - No hazard check, slot0 <= invalid, if_flush = 0, stall_pipeline = 1, pc/if_id enables = 1.
  - Next state RUN.
- pending_mask is the OR of one-hot(rd) over all valid slots, including the last slot, regardless of WRITE_THROUGH.
- Consecutive stall cycles are tracked by an internal run counter, cleared on any non-hazard cycle. When the run exceeds WB_LATENCY, stall_error is set and holds until reset.
- Simultaneous retire and issue of the same rd: the new entry is valid and the mask bit stays set.
- Worst-case stall for a back-to-back dependency:
  - WB_LATENCY cycles when WRITE_THROUGH = 0.
  - WB_LATENCY-1 cycles when WRITE_THROUGH = 1.

Decomposition:
- Shared package holds:
  - opcode constants RTYPE, STYPE, SBTYPE, ITYPE (load);
  - the FSM state encoding RUN / FLUSHED;
  - the slot struct {valid, rd}.
- One sub-module, scoreboard_slots: the parameterised shift register, compare and pending_mask generation.
- FSM, enables and counters stay in the top module.

Test Plan:
- Reset with slots loaded -> next cycle pending_mask = 0, pc_enable = 1, stall_count = 0.
- add x5 then add x6,x5,x1 back-to-back, WRITE_THROUGH = 0 -> stall_pipeline high for 3 cycles, pc_enable low for 3 cycles, stall_count = 3, issued on the 4th cycle.
- Same sequence with WRITE_THROUGH = 1 -> 2 stall cycles.
- Write to x0 followed by a read of x0 -> no stall; pending_mask = 0.
- beq x1,x2 taken, no hazard -> if_flush = 1 for one cycle; next cycle is a bubble (slot0 invalid, no stall_count increment); then RUN.
- beq dependent on in-flight x1 with branch_taken high -> if_flush held 0 while stalled.
- lw x7 depending on x3 in MEM -> stall until x3 retires.
- Force 5 consecutive stall cycles -> stall_error latches 1 until reset.
